// File: rtl/frame_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module  : frame_sync_pkg
// Brief   : Shared state encoding and sizing constants for frame sync control
// Revision: 1.0 - initial release
// ============================================================================
package frame_sync_pkg;

    localparam int HIT_W = 4;
    localparam int CNT_W = 16;

    // Defaults shared with the delay/data buffer sizing
    localparam int FRAME_LEN_DFLT   = 2560;
    localparam int HOLDOFF_LEN_DFLT = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEARCH  = 3'd1,
        ST_CONFIRM = 3'd2,
        ST_OUTPUT  = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fs_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : fs_sat_counter
// Brief   : Saturating up-counter with synchronous clear
// Revision: 1.0 - initial release
// ============================================================================
module fs_sat_counter
    import frame_sync_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/frame_sync_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : frame_sync_scheduler
// Brief   : Frame detection sequencer: search, confirm, output window, holdoff
// Revision: 1.0 - initial release
// ============================================================================
module frame_sync_scheduler
    import frame_sync_pkg::*;
#(
    parameter int CONFIRM_LEN = 4,
    parameter int FRAME_LEN   = FRAME_LEN_DFLT,
    parameter int HOLDOFF_LEN = HOLDOFF_LEN_DFLT
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Enable,
    input  logic        Abort,
    input  logic        DetVld,
    input  logic        DetHit,
    input  logic        OutVld,
    output logic        DetectEnable,
    output logic        BufferOutputEnable,
    output logic        FrameStart,
    output logic        FrameDone,
    output logic        FrameAbort,
    output logic        Busy,
    output logic [15:0] FrameCount
);

    localparam logic [HIT_W-1:0] C_CONF_LEN   = HIT_W'(CONFIRM_LEN);
    localparam logic [CNT_W-1:0] C_FRAME_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] C_HOLD_LAST  = CNT_W'(HOLDOFF_LEN - 1);

    state_t           state_q, state_d;
    logic [HIT_W-1:0] hit_q, hit_d;
    logic [CNT_W-1:0] smp_q, smp_d;
    logic [CNT_W-1:0] ho_q,  ho_d;

    logic det_en_q, buf_en_q, start_q, done_q, abort_q, busy_q;
    logic start_d, done_d, abort_d;

    always_comb begin
        state_d = state_q;
        hit_d   = hit_q;
        smp_d   = smp_q;
        ho_d    = ho_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        abort_d = 1'b0;

        // Abort outranks everything, including a coincident final sample
        if (Abort) begin
            state_d = ST_IDLE;
            hit_d   = '0;
            smp_d   = '0;
            ho_d    = '0;
            abort_d = (state_q == ST_OUTPUT);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Enable) state_d = ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (!Enable) begin
                        state_d = ST_IDLE;
                        hit_d   = '0;
                    end else if (DetVld && DetHit) begin
                        if (CONFIRM_LEN == 1) begin
                            state_d = ST_OUTPUT;
                            start_d = 1'b1;
                            hit_d   = '0;
                        end else begin
                            state_d = ST_CONFIRM;
                            hit_d   = {{(HIT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (!Enable) begin
                        state_d = ST_IDLE;
                        hit_d   = '0;
                    end else if (DetVld) begin
                        if (!DetHit) begin
                            state_d = ST_SEARCH;
                            hit_d   = '0;
                        end else if ((hit_q + 4'd1) == C_CONF_LEN) begin
                            state_d = ST_OUTPUT;
                            start_d = 1'b1;
                            hit_d   = '0;
                        end else begin
                            hit_d = hit_q + 4'd1;
                        end
                    end
                end
                ST_OUTPUT: begin
                    // Enable is only consulted once the frame has fully drained
                    if (OutVld) begin
                        if (smp_q == C_FRAME_LAST) begin
                            done_d  = 1'b1;
                            smp_d   = '0;
                            state_d = Enable ? ST_HOLDOFF : ST_IDLE;
                        end else begin
                            smp_d = smp_q + 16'd1;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (ho_q == C_HOLD_LAST) begin
                        ho_d    = '0;
                        state_d = Enable ? ST_SEARCH : ST_IDLE;
                    end else begin
                        ho_d = ho_q + 16'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q  <= ST_IDLE;
            hit_q    <= '0;
            smp_q    <= '0;
            ho_q     <= '0;
            det_en_q <= 1'b0;
            buf_en_q <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hit_q    <= hit_d;
            smp_q    <= smp_d;
            ho_q     <= ho_d;
            det_en_q <= (state_d != ST_IDLE);
            buf_en_q <= (state_d == ST_OUTPUT);
            start_q  <= start_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    fs_sat_counter #(
        .WIDTH (CNT_W)
    ) u_frame_cnt (
        .clk_i (Clk),
        .clr_i (!Rst_n),
        .inc_i (done_d),
        .cnt_o (FrameCount)
    );

    assign DetectEnable       = det_en_q;
    assign BufferOutputEnable = buf_en_q;
    assign FrameStart         = start_q;
    assign FrameDone          = done_q;
    assign FrameAbort         = abort_q;
    assign Busy               = busy_q;

endmodule
`default_nettype wire
